joy_db15_tx: RTL and testbench

- Device-side responder for the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shift chain.
- Snapshots two 16-bit joystick words when the host asserts LOAD, then shifts one bit onto DATA per host CLK rising edge.
- Used as a loopback/test source for the DB15 receiver path on the user port, and to drive the link from a core acting as a pad.
- Host pins are asynchronous to clk and are synchronized internally.

---
 rtl/joy_pkg.sv | 26 ++
 rtl/sync_edge.sv | 36 +++
 rtl/joy_db15_tx.sv | 126 ++++++++++++
 tb/tb_joy_db15_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared types and constants for the DB15 joystick serial responder.
package joy_pkg;

  localparam int PLAYER_BITS = 16;
  localparam int FRAME_BITS  = 32;
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } joy_state_e;

  // Wire order: player 1 first, bit 0 first; inverted when pressed drives low.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [PLAYER_BITS-1:0] p1,
    input logic [PLAYER_BITS-1:0] p2,
    input logic                   active_low
  );
    logic [FRAME_BITS-1:0] raw;
    raw = {p2, p1};
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses on the synced level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_sync = sync_q[STAGES-1];
  assign rise   = q_sync & ~prev_q;
  assign fall   = ~q_sync & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick link responder: '165-style parallel load, then one bit per host CLK rise.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW_DATA = 1'b1,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   joy_clk_in,
  input  logic                   joy_load_n,
  output logic                   joy_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout
);

  localparam logic            IDLE_LVL = ACTIVE_LOW_DATA;
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  joy_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  joy_data_q, joy_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_q, timeout_d;

  logic                  clk_rise, load_n_sync;
  logic                  clk_lvl_unused, clk_fall_unused;
  logic                  load_rise_unused, load_fall_unused;
  logic                  load_act;
  logic [FRAME_BITS-1:0] frame;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk    (clk),
    .reset  (reset),
    .d_in   (joy_clk_in),
    .q_sync (clk_lvl_unused),
    .rise   (clk_rise),
    .fall   (clk_fall_unused)
  );

  // Load strobe idles high, so its chain resets high to avoid a phantom load.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
    .clk    (clk),
    .reset  (reset),
    .d_in   (joy_load_n),
    .q_sync (load_n_sync),
    .rise   (load_rise_unused),
    .fall   (load_fall_unused)
  );

  assign load_act = ~load_n_sync;
  assign frame    = pack_frame(joystick1, joystick2, ACTIVE_LOW_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= {FRAME_BITS{IDLE_LVL}};
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      joy_data_q   <= IDLE_LVL;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      joy_data_q   <= joy_data_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  // Load beats a simultaneous clock edge in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (load_act) state_d = LOAD;
      LOAD:       if (!load_act) state_d = SHIFT;
      SHIFT: begin
        if (load_act)                                state_d = LOAD;
        else if (clk_rise && bit_cnt_q == CNT_LAST)  state_d = DONE;
        else if (!clk_rise && to_cnt_q == TO_LAST)   state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = '0;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    // Transparent while load is held; the last LOAD cycle's sample is the snapshot.
    if (state_d == LOAD || state_q == LOAD) begin
      shreg_d   = frame;
      bit_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (clk_rise) begin
        shreg_d      = {IDLE_LVL, shreg_q[FRAME_BITS-1:1]};
        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
        frame_done_d = (state_d == DONE);
      end else if (state_d == IDLE) begin
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = (to_cnt_q == {TW{1'b1}}) ? to_cnt_q : to_cnt_q + TW'(1);
      end
    end
    joy_data_d = (state_d == LOAD || state_d == SHIFT) ? shreg_d[0] : IDLE_LVL;
  end

  assign joy_data   = joy_data_q;
  assign busy       = (state_q == LOAD) || (state_q == SHIFT);
  assign frame_done = frame_done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: vector table, randomized frames and multi-cycle corner sequences.
module tb_joy_db15_tx;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        joy_clk_in = 1'b0;
  logic        joy_load_n = 1'b1;
  logic        joy_data, busy, frame_done, timeout;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int to_cnt = 0;

  always #10 clk = ~clk;

  joy_db15_tx #(.SYNC_STAGES(2), .ACTIVE_LOW_DATA(1'b1), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_clk_in (joy_clk_in),
    .joy_load_n (joy_load_n),
    .joy_data   (joy_data),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout    (timeout)
  );

  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (timeout)    to_cnt   <= to_cnt + 1;
  end

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    int          half;
    int          n_edges;
    int          exp_done;
    logic        exp_busy;
    logic        exp_last;
  } vec_t;

  vec_t vecs[5];

  // Wire bit k after k host edges: inverted button, idle-high once the frame is exhausted.
  function automatic logic exp_bit(input logic [31:0] snap, input int k);
    if (k >= 32) return 1'b1;
    return ~snap[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_load(input int cyc);
    joy_load_n = 1'b0;
    wait_cyc(cyc);
    joy_load_n = 1'b1;
    wait_cyc(6);
  endtask

  task automatic shift_edges(input logic [31:0] snap, input int first_k, input int n, input int half);
    for (int k = first_k; k < first_k + n; k++) begin
      joy_clk_in = 1'b1;
      wait_cyc(half);
      check($sformatf("bit%0d", k), joy_data, exp_bit(snap, k));
      joy_clk_in = 1'b0;
      wait_cyc(half);
    end
  endtask

  task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input int half,
                           input int n, input bit chg, input logic [15:0] c1, input logic [15:0] c2);
    logic [31:0] snap;
    joystick1 = j1;
    joystick2 = j2;
    snap = {j2, j1};
    host_load(10);
    if (chg) begin
      joystick1 = c1;
      joystick2 = c2;
    end
    check("busy_loaded", busy, 1'b1);
    check("bit0", joy_data, exp_bit(snap, 0));
    shift_edges(snap, 1, n, half);
  endtask

  initial begin
    int d0, t0;
    vecs[0] = '{j1: 16'h0001, j2: 16'h8000, half: 25, n_edges: 32, exp_done: 1, exp_busy: 1'b0, exp_last: 1'b1};
    vecs[1] = '{j1: 16'hFFFF, j2: 16'h0000, half: 8,  n_edges: 32, exp_done: 1, exp_busy: 1'b0, exp_last: 1'b1};
    vecs[2] = '{j1: 16'hA5A5, j2: 16'h3C3C, half: 8,  n_edges: 10, exp_done: 0, exp_busy: 1'b1, exp_last: 1'b0};
    vecs[3] = '{j1: 16'h0000, j2: 16'hFFFF, half: 6,  n_edges: 31, exp_done: 0, exp_busy: 1'b1, exp_last: 1'b0};
    vecs[4] = '{j1: 16'h1234, j2: 16'h8001, half: 8,  n_edges: 32, exp_done: 1, exp_busy: 1'b0, exp_last: 1'b1};

    wait_cyc(3);
    check("rst_joy_data", joy_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    reset = 1'b0;
    wait_cyc(4);
    check("idle_joy_data", joy_data, 1'b1);

    foreach (vecs[i]) begin
      d0 = done_cnt;
      run_frame(vecs[i].j1, vecs[i].j2, vecs[i].half, vecs[i].n_edges, 1'b0, 16'h0, 16'h0);
      wait_cyc(4);
      check($sformatf("vec%0d_last", i), joy_data, vecs[i].exp_last);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    // Extra host edges after a completed frame must not disturb the idle level.
    d0 = done_cnt;
    shift_edges(32'h0, 32, 3, 8);
    check("done_extra_busy", busy, 1'b0);
    check("done_extra_cnt", done_cnt - d0, 0);

    // Snapshot hold, then the next load picks up the new buttons.
    d0 = done_cnt;
    run_frame(16'h0001, 16'h8000, 8, 32, 1'b1, 16'hFFFF, 16'h8000);
    run_frame(16'hFFFF, 16'h8000, 8, 32, 1'b0, 16'h0, 16'h0);
    wait_cyc(4);
    check("snap_done", done_cnt - d0, 2);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      d0 = done_cnt;
      run_frame(a, b, 6 + r, 32, 1'b1, 16'($urandom), 16'($urandom));
      wait_cyc(4);
      check($sformatf("rand%0d_done", r), done_cnt - d0, 1);
      check($sformatf("rand%0d_idle", r), joy_data, 1'b1);
    end

    // Load and host clock land on the same synced cycle: load wins.
    d0 = done_cnt;
    run_frame(16'h1234, 16'h00F0, 8, 6, 1'b0, 16'h0, 16'h0);
    joystick1 = 16'h0001;
    joystick2 = 16'h5A5A;
    joy_clk_in = 1'b1;
    joy_load_n = 1'b0;
    wait_cyc(8);
    check("coll_joy_data", joy_data, exp_bit({16'h5A5A, 16'h0001}, 0));
    joy_clk_in = 1'b0;
    joy_load_n = 1'b1;
    wait_cyc(6);
    check("coll_bit0", joy_data, exp_bit({16'h5A5A, 16'h0001}, 0));
    shift_edges({16'h5A5A, 16'h0001}, 1, 32, 8);
    wait_cyc(4);
    check("coll_done", done_cnt - d0, 1);

    // Host clock stalls mid-frame.
    t0 = to_cnt;
    d0 = done_cnt;
    run_frame(16'h00FF, 16'hFF00, 8, 5, 1'b0, 16'h0, 16'h0);
    wait_cyc(TO + 10);
    check("to_pulses", to_cnt - t0, 1);
    check("to_busy", busy, 1'b0);
    check("to_joy_data", joy_data, 1'b1);
    shift_edges(32'h0, 32, 3, 8);
    check("to_after_pulses", to_cnt - t0, 1);
    check("to_done", done_cnt - d0, 0);

    // Reset in the middle of a shift.
    run_frame(16'h0F0F, 16'h1111, 8, 3, 1'b0, 16'h0, 16'h0);
    t0 = to_cnt;
    d0 = done_cnt;
    reset = 1'b1;
    wait_cyc(1);
    check("mid_rst_joy_data", joy_data, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    check("mid_rst_timeout", timeout, 1'b0);
    reset = 1'b0;
    wait_cyc(TO + 10);
    shift_edges(32'h0, 32, 2, 8);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_to", to_cnt - t0, 0);
    check("post_rst_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
